// File: rtl/pt_gen_pkg.sv
// Shared definitions for the plaintext candidate generator.
// Holds the FSM state encoding, the default character range and sizing constants.
package pt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] FIRST_CHAR_DEF = 8'h61;  // 'a'
    localparam logic [7:0] LAST_CHAR_DEF  = 8'h7A;  // 'z'

    localparam int MAX_CHARS = 16;
    localparam int LEN_W     = 5;
    localparam int PT_W      = 8 * MAX_CHARS;

    // Single-character candidate that every enumeration begins with.
    function automatic logic [PT_W-1:0] first_candidate(input logic [7:0] c);
        return {{(PT_W-8){1'b0}}, c};
    endfunction

endpackage

// File: rtl/pt_char_inc.sv
// One odometer digit: increments a character on carry-in, wrapping LAST_CHAR
// back to FIRST_CHAR and raising carry-out on the wrap.
module pt_char_inc
    import pt_gen_pkg::*;
#(
    parameter logic [7:0] FIRST_CHAR = FIRST_CHAR_DEF,
    parameter logic [7:0] LAST_CHAR  = LAST_CHAR_DEF
) (
    input  logic [7:0] ch,
    input  logic       cin,
    output logic [7:0] ch_nxt,
    output logic       cout
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ch_nxt = ch;
        cout   = 1'b0;
        if (cin) begin
            if (ch == LAST_CHAR) begin
                ch_nxt = FIRST_CHAR;
                cout   = 1'b1;
            end else begin
                ch_nxt = ch + 8'd1;
            end
        end
    end

endmodule

// File: rtl/pt_gen.sv
// Brute-force plaintext candidate generator: enumerates every string over
// [FIRST_CHAR..LAST_CHAR] of length 1..MAXLEN, one per accepted transfer.
module pt_gen
    import pt_gen_pkg::*;
#(
    parameter int         MAXLEN     = 8,
    parameter logic [7:0] FIRST_CHAR = FIRST_CHAR_DEF,
    parameter logic [7:0] LAST_CHAR  = LAST_CHAR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              ready,
    output logic              valid,
    output logic [PT_W-1:0]   pt,
    output logic [LEN_W-1:0]  pt_len,
    output logic              pt_ld,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAXLEN);

    state_t state, state_nxt;

    logic [MAX_CHARS:0]   carry;
    logic [MAX_CHARS-1:0] cin;
    logic [PT_W-1:0]      inc_pt;
    logic [PT_W-1:0]      pt_nxt;
    logic                 overflow;
    logic                 transfer;
    logic                 final_xfer;
    logic                 launch;

    // Carry only ripples through the characters currently in use; bytes
    // above pt_len stay zero until the length grows.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < MAX_CHARS; i++) begin : g_cell
        assign cin[i] = carry[i] & (pt_len > LEN_W'(i));

        pt_char_inc #(
            .FIRST_CHAR (FIRST_CHAR),
            .LAST_CHAR  (LAST_CHAR)
        ) u_inc (
            .ch     (pt[8*i +: 8]),
            .cin    (cin[i]),
            .ch_nxt (inc_pt[8*i +: 8]),
            .cout   (carry[i+1])
        );
    end

    always_comb begin
        overflow = 1'b0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (pt_len == LEN_W'(i + 1)) overflow = carry[i+1];
        end

        // On overflow the lower bytes have already wrapped to FIRST_CHAR;
        // only the newly added top character needs seeding.
        pt_nxt = inc_pt;
        if (overflow) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                if (pt_len == LEN_W'(i)) pt_nxt[8*i +: 8] = FIRST_CHAR;
            end
        end
    end

    assign transfer   = (state == RUN) & ready & ~stop;
    assign final_xfer = transfer & overflow & (pt_len == MAX_LEN);
    assign launch     = start & ~stop & (state != RUN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; stop overrides everything else.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)      state_nxt = RUN;
            RUN:     if (final_xfer) state_nxt = DONE;
            DONE:    if (start)      state_nxt = RUN;
            default:                 state_nxt = IDLE;
        endcase
        if (stop) state_nxt = IDLE;
    end

    // Output decode.
    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            RUN:     begin valid = 1'b1; busy = 1'b1; end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Candidate register; holds while the downstream stalls and after the last candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt     <= '0;
            pt_len <= '0;
            pt_ld  <= 1'b0;
        end else begin
            pt_ld <= transfer;
            if (launch) begin
                pt     <= first_candidate(FIRST_CHAR);
                pt_len <= LEN_W'(1);
            end else if (transfer && !final_xfer) begin
                pt     <= pt_nxt;
                pt_len <= pt_len + LEN_W'(overflow);
            end
        end
    end

endmodule

// File: tb/tb_pt_gen.sv
// Directed bench for pt_gen with MAXLEN=2 over 'a'..'z', checked against an odometer model.
module tb_pt_gen;

    localparam int MAXLEN = 2;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic         ready = 1'b0;
    logic         valid;
    logic [127:0] pt;
    logic [4:0]   pt_len;
    logic         pt_ld;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] m_pt;
    logic [4:0]   m_len;
    int           xfers;
    int           lds;
    int           k;
    logic         prev_x;

    pt_gen #(.MAXLEN(MAXLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .ready  (ready),
        .valid  (valid),
        .pt     (pt),
        .pt_len (pt_len),
        .pt_ld  (pt_ld),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Odometer over 'a'..'z' with length growth up to MAXLEN.
    task automatic model_step;
        logic c;
        c = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (c && i < int'(m_len)) begin
                if (m_pt[8*i +: 8] == 8'h7A) begin
                    m_pt[8*i +: 8] = 8'h61;
                end else begin
                    m_pt[8*i +: 8] = m_pt[8*i +: 8] + 8'd1;
                    c = 1'b0;
                end
            end
        end
        if (c && int'(m_len) < MAXLEN) begin
            m_pt[8*m_len +: 8] = 8'h61;
            m_len = m_len + 5'd1;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", valid, 0);
        check("rst_pt", pt, 0);
        check("rst_len", pt_len, 0);
        check("rst_ld", pt_ld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick;

        // Full run with ready held high; a stray start during RUN must be ignored
        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_valid", valid, 1);
        check("start_busy", busy, 1);
        check("start_pt", pt, 128'h61);
        check("start_len", pt_len, 1);
        check("start_ld", pt_ld, 0);
        m_pt  = 128'h61;
        m_len = 5'd1;
        xfers = 0;
        lds   = 0;
        ready = 1'b1;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            if (pt_ld) lds++;
            if (valid) begin
                check("run_pt", pt, m_pt);
                check("run_len", pt_len, m_len);
                case (xfers)
                    0:  check("seq_a", pt, 128'h61);
                    1:  check("seq_b", pt, 128'h62);
                    25: check("seq_z", pt, 128'h7A);
                    26: begin
                        check("seq_aa", pt, 128'h6161);
                        check("seq_aa_len", pt_len, 2);
                    end
                    default: ;
                endcase
                xfers++;
                model_step();
            end
            start = (xfers == 6);
            tick;
        end
        start = 1'b0;
        if (pt_ld) lds++;
        check("run_done", done, 1);
        check("run_xfers", xfers, 702);
        check("run_lds", lds, 702);
        check("end_pt", pt, 128'h7A7A);
        check("end_len", pt_len, 2);
        check("end_valid", valid, 0);
        check("end_busy", busy, 0);
        ready = 1'b0;
        tick;
        check("done_ld", pt_ld, 0);
        check("done_hold", done, 1);
        check("done_pt", pt, 128'h7A7A);

        // Restart from DONE
        start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_pt", pt, 128'h61);
        check("restart_len", pt_len, 1);

        // Random backpressure against the model
        m_pt   = 128'h61;
        m_len  = 5'd1;
        prev_x = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            check("bp_valid", valid, 1);
            check("bp_ld", pt_ld, prev_x);
            check("bp_pt", pt, m_pt);
            check("bp_len", pt_len, m_len);
            ready  = 1'($urandom_range(0, 1));
            prev_x = ready;
            if (ready) model_step();
            tick;
        end
        ready = 1'b0;

        // Stop back to IDLE, then stop+ready at 'q'
        stop = 1'b1;
        tick;
        stop = 1'b0;
        check("stop_valid", valid, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        ready = 1'b1;
        k = 0;
        while (pt != 128'h71 && k < 40) begin
            tick;
            k++;
        end
        check("reach_q", pt, 128'h71);
        stop = 1'b1;
        tick;
        stop  = 1'b0;
        ready = 1'b0;
        check("sq_valid", valid, 0);
        check("sq_busy", busy, 0);
        check("sq_ld", pt_ld, 0);
        tick;
        check("sq_ld2", pt_ld, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("sq_restart_pt", pt, 128'h61);
        check("sq_restart_len", pt_len, 1);

        // Asynchronous reset at "ab"
        ready = 1'b1;
        k = 0;
        while (pt != 128'h6261 && k < 100) begin
            tick;
            k++;
        end
        check("reach_ab", pt, 128'h6261);
        ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_pt", pt, 0);
        check("arst_len", pt_len, 0);
        check("arst_valid", valid, 0);
        check("arst_ld", pt_ld, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        #1;
        rst = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("arst_restart_pt", pt, 128'h61);
        check("arst_restart_len", pt_len, 1);
        check("arst_restart_valid", valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
